// File: rtl/imem_responder.sv
// imem_responder: pipelined instruction ROM with preload port and bad-address flagging; IMEM_EBREAK_ON_ERR_EN returns ebreak instead of NOP on bad fetches.
module imem_responder #(
    parameter int ADDR_W = 64,
    parameter int DEPTH_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h8000_0000,
    parameter int LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rom_ce,
    input  logic [ADDR_W-1:0]              pc_rom,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx,
    input  logic [31:0]                    ld_data,
    output logic [31:0]                    inst,
    output logic                           inst_valid,
    output logic                           addr_err
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_W+1)'(4 * DEPTH_WORDS);
`ifdef IMEM_EBREAK_ON_ERR_EN
    localparam logic [31:0] ERR_INST = 32'h0010_0073;
`else
    localparam logic [31:0] ERR_INST = 32'h0000_0013;
`endif
    logic [31:0]        mem [DEPTH_WORDS];
    logic [LATENCY-1:0] v;
    logic [LATENCY-1:0] e;
    logic [31:0]        d [LATENCY];
    logic [IW-1:0]      idx;
    logic               bad;
    always_comb begin
        idx = IW'((pc_rom - BASE_ADDR) >> 2);
        bad = (pc_rom[1:0] != 2'b00) || (pc_rom < BASE_ADDR) || ({1'b0, pc_rom} >= LIMIT);
    end
    always_ff @(posedge clk)
        if (ld_en) mem[ld_idx] <= ld_data;
    // Stage data holds across idle cycles so inst keeps the last response; error words are substituted on capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v <= '0;
            e <= '0;
            for (int i = 0; i < LATENCY; i++) d[i] <= '0;
        end else begin
            for (int i = LATENCY-1; i > 0; i--) begin
                v[i] <= v[i-1];
                e[i] <= e[i-1];
                d[i] <= d[i-1];
            end
            v[0] <= rom_ce;
            e[0] <= rom_ce && bad;
            d[0] <= rom_ce ? (bad ? ERR_INST : mem[idx]) : d[0];
        end
    end
    assign inst       = d[LATENCY-1];
    assign inst_valid = v[LATENCY-1];
    assign addr_err   = e[LATENCY-1];
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed checks of LATENCY 1, 3 and 4 instances sharing one stimulus stream.
module tb_imem_responder;
`ifdef IMEM_EBREAK_ON_ERR_EN
    localparam logic [31:0] ERR_INST = 32'h0010_0073;
`else
    localparam logic [31:0] ERR_INST = 32'h0000_0013;
`endif
    logic        clk = 0;
    logic        rst_n, rom_ce, ld_en;
    logic [63:0] pc_rom;
    logic [11:0] ld_idx;
    logic [31:0] ld_data;
    logic [31:0] inst1, inst3, inst4;
    logic        iv1, iv3, iv4, ae1, ae3, ae4;
    int          checks = 0;
    int          errors = 0;
    always #5 clk = ~clk;
    imem_responder #(.LATENCY(1)) u1 (.clk(clk), .rst_n(rst_n), .rom_ce(rom_ce), .pc_rom(pc_rom),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .inst(inst1), .inst_valid(iv1), .addr_err(ae1));
    imem_responder #(.LATENCY(3)) u3 (.clk(clk), .rst_n(rst_n), .rom_ce(rom_ce), .pc_rom(pc_rom),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .inst(inst3), .inst_valid(iv3), .addr_err(ae3));
    imem_responder #(.LATENCY(4)) u4 (.clk(clk), .rst_n(rst_n), .rom_ce(rom_ce), .pc_rom(pc_rom),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .inst(inst4), .inst_valid(iv4), .addr_err(ae4));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic preload(input logic [11:0] i, input logic [31:0] w);
        ld_en = 1; ld_idx = i; ld_data = w;
        step();
        ld_en = 0;
    endtask
    initial begin
        rst_n = 0; rom_ce = 0; ld_en = 0; pc_rom = 64'h8000_0000; ld_idx = 0; ld_data = 0;
        step();
        chk("rst_inst1", inst1, 32'h0);
        chk("rst_iv1", {31'b0, iv1}, 32'h0);
        chk("rst_ae1", {31'b0, ae1}, 32'h0);
        chk("rst_inst4", inst4, 32'h0);
        rst_n = 1;
        preload(12'd0, 32'h0000_0513);
        preload(12'd1, 32'h0010_0093);
        preload(12'd5, 32'hAAAA_AAAA);
        chk("idle_iv1", {31'b0, iv1}, 32'h0);
        // basic fetch and LATENCY=3 timing
        rom_ce = 1; pc_rom = 64'h8000_0000;
        step();
        chk("f0_inst1", inst1, 32'h0000_0513);
        chk("f0_iv1", {31'b0, iv1}, 32'h1);
        chk("f0_ae1", {31'b0, ae1}, 32'h0);
        chk("lat_k_iv3", {31'b0, iv3}, 32'h0);
        pc_rom = 64'h8000_0004;
        step();
        chk("f1_inst1", inst1, 32'h0010_0093);
        chk("f1_iv1", {31'b0, iv1}, 32'h1);
        chk("lat_k1_iv3", {31'b0, iv3}, 32'h0);
        rom_ce = 0;
        step();
        chk("gap0_iv1", {31'b0, iv1}, 32'h0);
        chk("gap0_inst1", inst1, 32'h0010_0093);
        chk("lat_k2_iv3", {31'b0, iv3}, 32'h1);
        chk("lat_k2_inst3", inst3, 32'h0000_0513);
        step();
        chk("gap1_iv1", {31'b0, iv1}, 32'h0);
        chk("gap1_inst1", inst1, 32'h0010_0093);
        chk("gap1_ae1", {31'b0, ae1}, 32'h0);
        chk("lat_k3_inst3", inst3, 32'h0010_0093);
        rom_ce = 1; pc_rom = 64'h8000_0000;
        step();
        chk("after_gap_inst1", inst1, 32'h0000_0513);
        chk("after_gap_iv1", {31'b0, iv1}, 32'h1);
        chk("gap_iv3", {31'b0, iv3}, 32'h0);
        // bad addresses and the last in-range word
        pc_rom = 64'h8000_0002;
        step();
        chk("mis_ae1", {31'b0, ae1}, 32'h1);
        chk("mis_inst1", inst1, ERR_INST);
        chk("mis_iv1", {31'b0, iv1}, 32'h1);
        pc_rom = 64'h7FFF_FFFC;
        step();
        chk("low_ae1", {31'b0, ae1}, 32'h1);
        chk("low_inst1", inst1, ERR_INST);
        pc_rom = 64'h8000_4000;
        step();
        chk("high_ae1", {31'b0, ae1}, 32'h1);
        chk("high_inst1", inst1, ERR_INST);
        chk("mis_ae3", {31'b0, ae3}, 32'h1);
        chk("mis_inst3", inst3, ERR_INST);
        pc_rom = 64'h8000_3FFC;
        step();
        chk("top_ae1", {31'b0, ae1}, 32'h0);
        chk("top_iv1", {31'b0, iv1}, 32'h1);
        // read/write collision
        pc_rom = 64'h8000_0014; ld_en = 1; ld_idx = 12'd5; ld_data = 32'h5555_5555;
        step();
        ld_en = 0;
        chk("coll_old", inst1, 32'hAAAA_AAAA);
        step();
        chk("coll_new", inst1, 32'h5555_5555);
        rom_ce = 0;
        for (int i = 0; i < 5; i++) step();
        chk("drain_iv4", {31'b0, iv4}, 32'h0);
        // reset flush on LATENCY=4
        rom_ce = 1; pc_rom = 64'h8000_0000;
        step();
        pc_rom = 64'h8000_0004;
        step();
        pc_rom = 64'h8000_0000;
        step();
        rom_ce = 0; rst_n = 0;
        step();
        chk("flush_inst4", inst4, 32'h0);
        chk("flush_iv4", {31'b0, iv4}, 32'h0);
        chk("flush_ae4", {31'b0, ae4}, 32'h0);
        chk("flush_inst1", inst1, 32'h0);
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_flush_iv4", {31'b0, iv4}, 32'h0);
            chk("post_flush_inst4", inst4, 32'h0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
